// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD counter sequencer.
//   bcd_t            : one BCD digit (raw 4 bits, values A-F are possible on load)
//   BCD_MAX/BCD_MIN  : digit wrap points
//   bcd_ctrl_state_t : sequencer states, 2-bit encoding
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } bcd_ctrl_state_t;

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational next-value logic for a single BCD digit.
// Ports:
//   digit      in  4  current digit value
//   up         in  1  1 = increment, 0 = decrement
//   en         in  1  digit is allowed to change on this step
//   next_digit out 4  value after the step (equals digit when en = 0)
//   at_limit   out 1  digit sits at its wrap point for the current direction;
//                     chained to enable the next-higher digit
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_t digit,
    input  logic up,
    input  logic en,
    output bcd_t next_digit,
    output logic at_limit
);

    always_comb begin
        // Codes A-F behave as a wrap point in either direction, so a bad
        // loaded digit self-corrects to 0 (up) or 9 (down) on the first step.
        if (up) begin
            at_limit = (digit >= BCD_MAX);
        end else begin
            at_limit = (digit == BCD_MIN) || (digit > BCD_MAX);
        end

        next_digit = digit;
        if (en) begin
            if (at_limit) begin
                next_digit = up ? BCD_MIN : BCD_MAX;
            end else begin
                next_digit = up ? (digit + 4'd1) : (digit - 4'd1);
            end
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencer for a multi-digit BCD up/down counter chain with run/pause/stop
// control, parallel load, tick prescaler and terminal-value detection.
// Ports:
//   clk       in   1         rising-edge clock
//   reset_n   in   1         asynchronous active-low reset
//   start     in   1         IDLE/DONE/PAUSE -> RUN
//   pause     in   1         RUN -> PAUSE
//   stop      in   1         any state -> IDLE, count retained
//   up        in   1         count direction, sampled on each step
//   load      in   1         count <= load_val (IDLE/PAUSE/DONE only)
//   load_val  in   4*DIGITS  BCD load value, digit0 in the LSBs
//   target    in   4*DIGITS  terminal value, raw equality compare
//   count     out  4*DIGITS  current count (the register itself)
//   step      out  1         registered pulse on every count update
//   wrap      out  1         registered pulse when the whole chain wraps
//   done      out  1         registered, high in DONE
//   busy      out  1         registered, high in RUN
//   state     out  2         current sequencer state (debug visibility)
// Command priority each cycle: stop > load > pause > start.
module bcd_count_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   count,
    output logic                  step,
    output logic                  wrap,
    output logic                  done,
    output logic                  busy,
    output bcd_ctrl_state_t       state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    bcd_ctrl_state_t      state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [4*DIGITS-1:0]  count_d, stepped;
    logic                 step_d, wrap_d;
    logic [DIGITS:0]      en_chain;
    logic [DIGITS-1:0]    at_lim;
    logic                 hit;

    // Ripple enable: digit i moves only when every lower digit is at its
    // wrap point. Carry out of the top digit is a whole-chain wrap.
    assign en_chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .digit      (count[4*g +: 4]),
            .up         (up),
            .en         (en_chain[g]),
            .next_digit (stepped[4*g +: 4]),
            .at_limit   (at_lim[g])
        );
        assign en_chain[g+1] = en_chain[g] & at_lim[g];
    end

    // step is high for exactly the cycle after a count update, so this
    // marks "the step just taken landed on target". RUN entry never has
    // step high, which gives the first step even when count == target.
    assign hit = step && (count == target);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count;
        step_d  = 1'b0;
        wrap_d  = 1'b0;

        if (stop) begin
            state_d = IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        count_d = load_val;
                    end else if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        // Prescaler left as-is so resume finishes the period.
                        state_d = PAUSE;
                    end else if (hit) begin
                        state_d = DONE;
                        presc_d = '0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        count_d = stepped;
                        step_d  = 1'b1;
                        wrap_d  = en_chain[DIGITS];
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE, DONE: begin
                    if (load) begin
                        count_d = load_val;
                    end else if (start) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            count   <= '0;
            step    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count   <= count_d;
            step    <= step_d;
            wrap    <= wrap_d;
            done    <= (state_d == DONE);
            busy    <= (state_d == RUN);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Testbench for bcd_count_ctrl: two instances (TICK_DIV = 1 and 4), each
// with a monitor that pops the expected {wrap, count} on every step pulse.
module tb_bcd_count_ctrl;
    import bcd_pkg::*;

    localparam int DG = 4;
    localparam int W  = 4*DG;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    // instance A: TICK_DIV = 1
    logic start_a = 0, pause_a = 0, stop_a = 0, up_a = 1, load_a = 0;
    logic [W-1:0] load_val_a = '0, target_a = '0, count_a;
    logic step_a, wrap_a, done_a, busy_a;
    bcd_ctrl_state_t state_a;

    // instance B: TICK_DIV = 4
    logic start_b = 0, pause_b = 0, stop_b = 0, up_b = 1, load_b = 0;
    logic [W-1:0] load_val_b = '0, target_b = 16'h5555, count_b;
    logic step_b, wrap_b, done_b, busy_b;
    bcd_ctrl_state_t state_b;

    logic [W:0] exp_q_a[$];
    logic [W:0] exp_q_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    bcd_count_ctrl #(.DIGITS(DG), .TICK_DIV(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .pause(pause_a),
        .stop(stop_a), .up(up_a), .load(load_a), .load_val(load_val_a),
        .target(target_a), .count(count_a), .step(step_a), .wrap(wrap_a),
        .done(done_a), .busy(busy_a), .state(state_a)
    );

    bcd_count_ctrl #(.DIGITS(DG), .TICK_DIV(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .pause(pause_b),
        .stop(stop_b), .up(up_b), .load(load_b), .load_val(load_val_b),
        .target(target_b), .count(count_b), .step(step_b), .wrap(wrap_b),
        .done(done_b), .busy(busy_b), .state(state_b)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic w, input logic [W-1:0] c);
        exp_q_a.push_back({w, c});
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
    endtask

    task automatic load_a_val(input logic [W-1:0] v);
        load_val_a = v;
        load_a = 1'b1;
        cycle();
        load_a = 1'b0;
    endtask

    // RUN entry, exactly one step, then stop back to IDLE
    task automatic run_one_step_a();
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        cycle();
        stop_a = 1'b1;
        cycle();
        stop_a = 1'b0;
    endtask

    task automatic wait_done_a(output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            cycle();
            if (done_a) begin
                lat = i;
                break;
            end
        end
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n && step_a) begin
            if (exp_q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_step_unexpected: got %0h expected none", {wrap_a, count_a});
            end else begin
                check("a_step", 32'({wrap_a, count_a}), 32'(exp_q_a.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && step_b) begin
            if (exp_q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_step_unexpected: got %0h expected none", {wrap_b, count_b});
            end else begin
                check("b_step", 32'({wrap_b, count_b}), 32'(exp_q_b.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int v;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        check("reset_count_a", 32'(count_a), 32'h0);
        check("reset_flags_a", 32'({step_a, wrap_a, done_a, busy_a}), 32'h0);
        check("reset_state_a", 32'(state_a), 32'(IDLE));
        check("reset_count_b", 32'(count_b), 32'h0);
        check("reset_flags_b", 32'({step_b, wrap_b, done_b, busy_b}), 32'h0);

        // 1: count up 00..12, DONE the cycle after reaching 12
        up_a = 1'b1;
        target_a = 16'h0012;
        for (int i = 1; i <= 12; i++) begin
            v = (i < 10) ? i : (16 + i - 10);
            push_a(1'b0, W'(v));
        end
        pulse_start_a();
        check("t1_busy", 32'(busy_a), 32'h1);
        wait_done_a(lat);
        check("t1_done_latency", 32'(lat), 32'd13);
        check("t1_count", 32'(count_a), 32'h0012);
        check("t1_busy_done", 32'(busy_a), 32'h0);

        // 2: carry across digits and whole-chain wrap (load in DONE first)
        target_a = 16'h5555;
        load_a_val(16'h0999);
        check("t2_load_in_done", 32'(count_a), 32'h0999);
        check("t2_done_kept", 32'(done_a), 32'h1);
        push_a(1'b0, 16'h1000);
        run_one_step_a();
        check("t2_carry", 32'(count_a), 32'h1000);
        check("t2_stop_idle", 32'(state_a), 32'(IDLE));
        load_a_val(16'h9999);
        push_a(1'b1, 16'h0000);
        run_one_step_a();
        check("t2_wrap_up", 32'(count_a), 32'h0000);

        // 3: count down 0100 -> 0097 then borrow wrap 0000 -> 9999
        up_a = 1'b0;
        load_a_val(16'h0100);
        target_a = 16'h0097;
        push_a(1'b0, 16'h0099);
        push_a(1'b0, 16'h0098);
        push_a(1'b0, 16'h0097);
        pulse_start_a();
        wait_done_a(lat);
        check("t3_done_latency", 32'(lat), 32'd4);
        check("t3_count", 32'(count_a), 32'h0097);
        load_a_val(16'h0000);
        check("t3_load_done", 32'({done_a, count_a}), 32'h1_0000);
        target_a = 16'h5555;
        push_a(1'b1, 16'h9999);
        run_one_step_a();
        check("t3_wrap_down", 32'(count_a), 32'h9999);

        // 5: priority cases
        up_a = 1'b1;
        start_a = 1'b1;
        stop_a = 1'b1;
        cycle();
        start_a = 1'b0;
        stop_a = 1'b0;
        check("t5_stop_start_idle", 32'(state_a), 32'(IDLE));
        pulse_start_a();
        start_a = 1'b1;
        stop_a = 1'b1;
        cycle();
        start_a = 1'b0;
        stop_a = 1'b0;
        check("t5_stop_start_run", 32'({busy_a, count_a}), 32'h0_9999);
        load_a_val(16'h0040);
        push_a(1'b0, 16'h0041);
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        load_val_a = 16'h0700;
        load_a = 1'b1;
        cycle();
        load_a = 1'b0;
        stop_a = 1'b1;
        cycle();
        stop_a = 1'b0;
        check("t5_load_in_run", 32'(count_a), 32'h0041);
        pulse_start_a();
        pause_a = 1'b1;
        start_a = 1'b1;
        cycle();
        pause_a = 1'b0;
        start_a = 1'b0;
        check("t5_pause_start", 32'(state_a), 32'(PAUSE));
        check("t5_pause_count", 32'(count_a), 32'h0041);
        stop_a = 1'b1;
        cycle();
        stop_a = 1'b0;

        // 4: prescaler freeze across PAUSE on instance B
        start_b = 1'b1;
        cycle();
        start_b = 1'b0;
        cycle();
        cycle();
        pause_b = 1'b1;
        cycle();
        pause_b = 1'b0;
        check("t4_paused", 32'(state_b), 32'(PAUSE));
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t4_hold_count", 32'({step_b, count_b}), 32'h0_0000);
        end
        exp_q_b.push_back({1'b0, 16'h0001});
        start_b = 1'b1;
        cycle();
        start_b = 1'b0;
        check("t4_resume_busy", 32'({busy_b, step_b}), 32'h2);
        cycle();
        check("t4_no_step_early", 32'(step_b), 32'h0);
        cycle();
        check("t4_step_after_2", 32'({step_b, count_b}), 32'h1_0001);
        exp_q_b.push_back({1'b0, 16'h0002});
        cycle();
        cycle();
        cycle();
        check("t4_full_period_gap", 32'(step_b), 32'h0);
        cycle();
        check("t4_full_period", 32'({step_b, count_b}), 32'h1_0002);
        stop_b = 1'b1;
        cycle();
        stop_b = 1'b0;

        // 6: asynchronous reset in the middle of a run
        load_a_val(16'h0000);
        push_a(1'b0, 16'h0001);
        push_a(1'b0, 16'h0002);
        push_a(1'b0, 16'h0003);
        pulse_start_a();
        cycle();
        cycle();
        cycle();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_async_count", 32'(count_a), 32'h0);
        check("t6_async_flags", 32'({step_a, wrap_a, done_a, busy_a}), 32'h0);
        check("t6_async_state", 32'(state_a), 32'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        check("t6_after_release", 32'({busy_a, count_a}), 32'h0_0000);
        push_a(1'b0, 16'h0001);
        run_one_step_a();
        check("t6_restart", 32'(count_a), 32'h0001);

        cycle();
        check("queue_a_empty", 32'(exp_q_a.size()), 32'h0);
        check("queue_b_empty", 32'(exp_q_b.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
